// File: rtl/time_ascii_pkg.sv
// Shared types, ASCII constants and sizing helpers for the BCD time-string streamer.
package time_ascii_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;

    typedef enum logic [1:0] {K_DIGIT, K_SEP, K_CR, K_LF} kind_e;

    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    function automatic int str_len(input int nf, input int dpf, input int crlf);
        return nf * dpf + (nf - 1) + ((crlf != 0) ? 2 : 0);
    endfunction

    // Index widths never collapse to zero bits, even for one-entry ranges.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// Maps one BCD nibble to its ASCII digit; codes above 9 become the configured invalid-character byte.
module bcd_to_ascii
    import time_ascii_pkg::*;
#(
    parameter logic [7:0] INVALID_CHAR = 8'h3F
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = (nibble <= 4'd9) ? (ZERO + {4'h0, nibble}) : INVALID_CHAR;

endmodule

// File: rtl/time_ascii_streamer.sv
// Snapshots a packed BCD time, formats it as an ASCII string and streams it
// byte by byte over a valid/ready handshake.
module time_ascii_streamer
    import time_ascii_pkg::*;
#(
    parameter int          NUM_FIELDS       = 4,
    parameter int          DIGITS_PER_FIELD = 2,
    parameter logic [7:0]  SEP_CHAR         = 8'h3A,
    parameter int          APPEND_CRLF      = 1,
    parameter logic [7:0]  INVALID_CHAR     = 8'h3F
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_start,
    input  logic [NUM_FIELDS*DIGITS_PER_FIELD*4-1:0] i_digits,
    input  logic                                   i_tx_ready,
    output logic [7:0]                             o_tx_data,
    output logic                                   o_tx_valid,
    output logic                                   o_busy,
    output logic                                   o_done
);

    localparam int LEN   = str_len(NUM_FIELDS, DIGITS_PER_FIELD, APPEND_CRLF);
    localparam int NDIG  = NUM_FIELDS * DIGITS_PER_FIELD;
    localparam int IDX_W = width_of(LEN);
    localparam int NIB_W = width_of(NDIG);
    localparam int BODY  = NUM_FIELDS * (DIGITS_PER_FIELD + 1) - 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

    state_e               state_reg, state_next;
    logic [NDIG*4-1:0]    snap_reg;
    logic [IDX_W-1:0]     index_reg;
    logic [IDX_W-1:0]     sel_idx;
    logic [7:0]           data_reg;
    kind_e                pos_kind [LEN];
    logic [NIB_W-1:0]     pos_nib  [LEN];
    logic [3:0]           nibble;
    logic [7:0]           digit_char;
    logic [7:0]           byte_sel;
    logic                 xfer;

    // Constant per-position table: what kind of byte sits there and which nibble feeds it.
    genvar gi;
    generate
        for (gi = 0; gi < LEN; gi++) begin : g_pos
            localparam int SLOT   = gi / (DIGITS_PER_FIELD + 1);
            localparam int WITHIN = gi % (DIGITS_PER_FIELD + 1);
            if (gi == BODY) begin : g_cr
                assign pos_kind[gi] = K_CR;
                assign pos_nib[gi]  = '0;
            end else if (gi > BODY) begin : g_lf
                assign pos_kind[gi] = K_LF;
                assign pos_nib[gi]  = '0;
            end else if (WITHIN == DIGITS_PER_FIELD) begin : g_sep
                assign pos_kind[gi] = K_SEP;
                assign pos_nib[gi]  = '0;
            end else begin : g_dig
                assign pos_kind[gi] = K_DIGIT;
                assign pos_nib[gi]  = NIB_W'((NUM_FIELDS - 1 - SLOT) * DIGITS_PER_FIELD
                                            + (DIGITS_PER_FIELD - 1 - WITHIN));
            end
        end
    endgenerate

    // LOAD fetches byte 0; SEND pre-fetches the byte after the one on the bus.
    always_comb begin
        sel_idx = index_reg;
        if (state_reg == SEND && index_reg != LAST) begin
            sel_idx = index_reg + 1'b1;
        end
    end

    assign nibble = snap_reg[4*int'(pos_nib[sel_idx]) +: 4];

    bcd_to_ascii #(
        .INVALID_CHAR (INVALID_CHAR)
    ) u_bcd_to_ascii (
        .nibble (nibble),
        .ascii  (digit_char)
    );

    always_comb begin
        byte_sel = digit_char;
        case (pos_kind[sel_idx])
            K_DIGIT: byte_sel = digit_char;
            K_SEP:   byte_sel = SEP_CHAR;
            K_CR:    byte_sel = CR;
            K_LF:    byte_sel = LF;
            default: byte_sel = digit_char;
        endcase
    end

    assign xfer = (state_reg == SEND) && i_tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_tx_valid = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_next = LOAD;
            end
            LOAD: state_next = SEND;
            SEND: begin
                o_tx_valid = 1'b1;
                if (xfer && index_reg == LAST) state_next = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_reg  <= '0;
            index_reg <= '0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        snap_reg  <= i_digits;
                        index_reg <= '0;
                    end
                end
                LOAD: data_reg <= byte_sel;
                SEND: begin
                    if (xfer && index_reg != LAST) begin
                        index_reg <= index_reg + 1'b1;
                        data_reg  <= byte_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data = data_reg;

endmodule

// File: tb/tb_time_ascii_streamer.sv
// Directed bench: default-parameter streamer driven from a vector table, plus a
// three-field no-CRLF instance and a mid-string reset sequence.
module tb_time_ascii_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, ready_a;
    logic [31:0] digits_a;
    logic [7:0]  data_a;
    logic        valid_a, busy_a, done_a;
    logic        start_b, ready_b;
    logic [23:0] digits_b;
    logic [7:0]  data_b;
    logic        valid_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0]  digits;
        logic         alt;
        logic         mid;
        logic [103:0] exp;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    time_ascii_streamer u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (start_a),
        .i_digits   (digits_a),
        .i_tx_ready (ready_a),
        .o_tx_data  (data_a),
        .o_tx_valid (valid_a),
        .o_busy     (busy_a),
        .o_done     (done_a)
    );

    time_ascii_streamer #(
        .NUM_FIELDS  (3),
        .APPEND_CRLF (0)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (start_b),
        .i_digits   (digits_b),
        .i_tx_ready (ready_b),
        .o_tx_data  (data_b),
        .o_tx_valid (valid_b),
        .o_busy     (busy_b),
        .o_done     (done_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle again.
    task automatic run_a(input vec_t v, input int vi);
        int cnt;
        int k;
        logic stalled, fired, rdy;
        logic [7:0] held;
        digits_a = v.digits;
        start_a  = 1'b1;
        ready_a  = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        check($sformatf("v%0d busy_load", vi), busy_a, 1);
        check($sformatf("v%0d valid_load", vi), valid_a, 0);
        cnt = 0; k = 0; stalled = 1'b0; fired = 1'b0; held = 8'h00;
        while (cnt < 13 && k < 200) begin
            rdy = v.alt ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            ready_a = rdy;
            if (stalled) begin
                check($sformatf("v%0d hold_valid", vi), valid_a, 1);
                check($sformatf("v%0d hold_data", vi), data_a, held);
            end
            if (valid_a && rdy) begin
                check($sformatf("v%0d byte%0d", vi, cnt), data_a, v.exp[(12-cnt)*8 +: 8]);
                cnt++;
            end
            stalled = valid_a && !rdy;
            held    = data_a;
            if (v.mid && cnt == 3 && !fired) begin
                digits_a = 32'h99999999;
                start_a  = 1'b1;
                fired    = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        start_a = 1'b0;
        ready_a = 1'b0;
        check($sformatf("v%0d byte_count", vi), cnt, 13);
        if (!v.alt) check($sformatf("v%0d cycles", vi), k, 14);
        check($sformatf("v%0d done_pulse", vi), done_a, 1);
        check($sformatf("v%0d valid_after", vi), valid_a, 0);
        @(negedge clk);
        check($sformatf("v%0d done_clear", vi), done_a, 0);
        check($sformatf("v%0d busy_fall", vi), busy_a, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("v%0d idle_busy", vi), busy_a, 0);
            check($sformatf("v%0d idle_done", vi), done_a, 0);
        end
        $display("vector %0d digits=%h alt=%0d bytes=%0d", vi, v.digits, v.alt, cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int k;
        logic found;
        logic [63:0] exp_b;

        vecs[0] = '{digits: 32'h12345678, alt: 1'b0, mid: 1'b0, exp: 104'h31323A33343A35363A37380D0A};
        vecs[1] = '{digits: 32'h12345678, alt: 1'b1, mid: 1'b0, exp: 104'h31323A33343A35363A37380D0A};
        vecs[2] = '{digits: 32'h0A59F000, alt: 1'b0, mid: 1'b0, exp: 104'h303F3A35393A3F303A30300D0A};
        vecs[3] = '{digits: 32'h00000000, alt: 1'b0, mid: 1'b1, exp: 104'h30303A30303A30303A30300D0A};
        vecs[4] = '{digits: 32'h9ABCDEF0, alt: 1'b1, mid: 1'b0, exp: 104'h393F3A3F3F3A3F3F3A3F300D0A};

        reset_n = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; digits_a = '0;
        start_b = 1'b0; ready_b = 1'b0; digits_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst valid_a", valid_a, 0);
        check("rst busy_a", busy_a, 0);
        check("rst done_a", done_a, 0);
        check("rst data_a", data_a, 0);
        check("rst valid_b", valid_b, 0);
        check("rst busy_b", busy_b, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_a(vecs[i], i);

        // Asynchronous reset while the fifth byte is on the bus.
        digits_a = 32'h12345678;
        start_a  = 1'b1;
        ready_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0; k = 0; found = 1'b0;
        while (!found && k < 50) begin
            if (valid_a) begin
                if (cnt == 4) found = 1'b1;
                else cnt++;
            end
            if (!found) begin
                k++;
                @(negedge clk);
            end
        end
        ready_a = 1'b0;
        check("rst_mid reached_byte5", found, 1);
        check("rst_mid byte5_data", data_a, 8'h34);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid valid", valid_a, 0);
        check("rst_mid busy", busy_a, 0);
        check("rst_mid done", done_a, 0);
        check("rst_mid data", data_a, 0);
        $display("async reset mid-string at byte index %0d", cnt);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_a(vecs[0], 5);

        // Three fields, no CR/LF.
        exp_b    = 64'h32333A35393A3539;
        digits_b = 24'h235959;
        start_b  = 1'b1;
        ready_b  = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cnt = 0; k = 0;
        while (cnt < 8 && k < 100) begin
            if (valid_b) begin
                check($sformatf("b byte%0d", cnt), data_b, exp_b[(7-cnt)*8 +: 8]);
                cnt++;
            end
            k++;
            @(negedge clk);
        end
        ready_b = 1'b0;
        check("b byte_count", cnt, 8);
        check("b done_pulse", done_b, 1);
        check("b valid_after", valid_b, 0);
        @(negedge clk);
        check("b done_clear", done_b, 0);
        check("b busy_fall", busy_b, 0);
        $display("short string bytes=%0d", cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
